// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: Tx substate encodings, ordered-set types and the PAD link symbol.
package ltssm_pkg;

    typedef enum logic [3:0] {
        DETECT_QUIET    = 4'd0,
        DETECT_ACTIVE   = 4'd1,
        POLLING_ACTIVE  = 4'd2,
        POLLING_CONFIG  = 4'd3,
        CFG_LW_START    = 4'd4,
        CFG_LW_ACCEPT   = 4'd5,
        CFG_LN_WAIT     = 4'd6,
        CFG_LN_ACCEPT   = 4'd7,
        CFG_COMPLETE    = 4'd8,
        CFG_IDLE        = 4'd9,
        L0              = 4'd10
    } substate_e;

    typedef enum logic [1:0] {
        OS_NONE = 2'd0,
        OS_TS1  = 2'd1,
        OS_TS2  = 2'd2,
        OS_IDLE = 2'd3
    } os_type_e;

    localparam logic [7:0] PAD = 8'hF7;

    // Encodings above L0 are unused and fall back to detectQuiet.
    function automatic substate_e decode_substate(input logic [3:0] s);
        return (s > 4'd10) ? DETECT_QUIET : substate_e'(s);
    endfunction

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Per-substate cycle counter with synchronous clear; flags expiry at TIMEOUT_CYCLES-1.
module ltssm_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    output logic [23:0] cnt,
    output logic        expired
);

    logic [23:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && cnt_q != '1)
            cnt_d = cnt_q + 24'd1;
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt     = cnt_q;
    assign expired = (cnt_q == 24'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tx_ltssm_substate.sv
// Transmit-side LTSSM slave: runs the commanded Tx substate, drives the ordered-set
// generator and receiver-detect handshakes, and reports finishTx/gotoTx upstream.
module tx_ltssm_substate
    import ltssm_pkg::*;
#(
    parameter int DEVICETYPE     = 0,
    parameter int QUIET_CYCLES   = 16,
    parameter int POLL_TS1_COUNT = 1024,
    parameter int CFG_TS_COUNT   = 16,
    parameter int IDLE_COUNT     = 16,
    parameter int TIMEOUT_CYCLES = 24000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] substateTx,
    input  logic [7:0] linkNumberIn,
    input  logic       rxDetectDone,
    input  logic       rxDetected,
    input  logic       osReady,
    output logic       osValid,
    output logic [1:0] osType,
    output logic [7:0] osLinkNumber,
    output logic       rxDetectReq,
    output logic       electricalIdle,
    output logic       finishTx,
    output logic [3:0] gotoTx
);

    logic [3:0]  prev_substate_q, prev_substate_d;
    logic [10:0] os_cnt_q, os_cnt_d;
    logic        os_valid_q, os_valid_d;
    logic [1:0]  os_type_q, os_type_d;
    logic [7:0]  link_q, link_d;
    logic        rxdet_req_q, rxdet_req_d;
    logic        eidle_q, eidle_d;
    logic        finish_q, finish_d;
    logic [3:0]  goto_q, goto_d;

    substate_e   cur;
    logic        changed, hs, done;
    logic [10:0] os_cnt_inc, target;
    logic [1:0]  os_kind;
    logic [7:0]  link_sel;
    substate_e   os_next, goto_n;
    logic [23:0] tmr_cnt;
    logic        tmr_expired, tmr_en;

    assign cur     = decode_substate(substateTx);
    assign changed = (substateTx != prev_substate_q);
    assign hs      = os_valid_q & osReady;
    // osCnt saturates instead of wrapping.
    assign os_cnt_inc = (os_cnt_q == '1) ? os_cnt_q : os_cnt_q + {10'd0, hs};
    // Timer stops once the substate has finished and never runs in L0.
    assign tmr_en  = !finish_q && (cur != L0);

    ltssm_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (changed),
        .en      (tmr_en),
        .cnt     (tmr_cnt),
        .expired (tmr_expired)
    );

    // Ordered-set parameters of the current substate: type, count, link field, successor.
    always_comb begin
        os_kind  = OS_TS1;
        target   = 11'(CFG_TS_COUNT);
        os_next  = DETECT_QUIET;
        if (DEVICETYPE == 0)
            link_sel = linkNumberIn;
        else
            link_sel = (linkNumberIn != PAD) ? linkNumberIn : PAD;
        case (cur)
            POLLING_ACTIVE: begin
                target = 11'(POLL_TS1_COUNT); os_next = POLLING_CONFIG; link_sel = PAD;
            end
            POLLING_CONFIG: begin
                os_kind = OS_TS2; os_next = CFG_LW_START; link_sel = PAD;
            end
            CFG_LW_START:  os_next = CFG_LW_ACCEPT;
            CFG_LW_ACCEPT: os_next = CFG_LN_WAIT;
            CFG_LN_WAIT:   os_next = CFG_LN_ACCEPT;
            CFG_LN_ACCEPT: os_next = CFG_COMPLETE;
            CFG_COMPLETE: begin
                os_kind = OS_TS2; os_next = CFG_IDLE;
            end
            CFG_IDLE: begin
                os_kind = OS_IDLE; target = 11'(IDLE_COUNT); os_next = L0;
            end
            default: ;
        endcase
    end

    // Substate FSM next-state: change handling, per-substate actions, finish/timeout.
    always_comb begin
        prev_substate_d = substateTx;
        os_cnt_d        = os_cnt_q;
        os_valid_d      = os_valid_q;
        os_type_d       = os_type_q;
        link_d          = link_q;
        rxdet_req_d     = rxdet_req_q;
        eidle_d         = eidle_q;
        finish_d        = finish_q;
        goto_d          = goto_q;
        done            = 1'b0;
        goto_n          = DETECT_QUIET;

        if (changed) begin
            // New substate: wipe progress this cycle, act from the next one.
            os_cnt_d    = '0;
            os_valid_d  = 1'b0;
            rxdet_req_d = 1'b0;
            finish_d    = 1'b0;
        end else if (finish_q) begin
            // Hold finishTx/gotoTx until the main LTSSM moves on.
            os_valid_d  = 1'b0;
            rxdet_req_d = 1'b0;
        end else begin
            case (cur)
                DETECT_QUIET: begin
                    eidle_d    = 1'b1;
                    os_valid_d = 1'b0;
                    if (tmr_cnt == 24'(QUIET_CYCLES - 1)) begin
                        done = 1'b1; goto_n = DETECT_ACTIVE;
                    end
                end
                DETECT_ACTIVE: begin
                    eidle_d    = 1'b1;
                    os_valid_d = 1'b0;
                    if (rxdet_req_q && rxDetectDone) begin
                        rxdet_req_d = 1'b0;
                        done        = 1'b1;
                        goto_n      = rxDetected ? POLLING_ACTIVE : DETECT_QUIET;
                    end else begin
                        rxdet_req_d = 1'b1;
                    end
                end
                L0: begin
                    os_valid_d = 1'b0;
                    eidle_d    = 1'b0;
                end
                default: begin
                    eidle_d  = 1'b0;
                    os_cnt_d = os_cnt_inc;
                    if (os_cnt_q >= target) begin
                        done = 1'b1; goto_n = os_next; os_valid_d = 1'b0;
                    end else begin
                        // Drop valid right after the last handshake so no extra OS slips out.
                        os_valid_d = (os_cnt_inc < target);
                        // Only load a new OS when none is pending, keeping a stalled one stable.
                        if (!os_valid_q || hs) begin
                            os_type_d = os_kind;
                            link_d    = link_sel;
                        end
                    end
                end
            endcase

            // Normal completion takes priority over a coincident timeout.
            if (done) begin
                finish_d = 1'b1;
                goto_d   = goto_n;
            end else if (tmr_expired && cur != L0) begin
                finish_d    = 1'b1;
                goto_d      = DETECT_QUIET;
                os_valid_d  = 1'b0;
                rxdet_req_d = 1'b0;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_substate_q <= DETECT_QUIET;
            os_cnt_q        <= '0;
            os_valid_q      <= 1'b0;
            os_type_q       <= OS_NONE;
            link_q          <= PAD;
            rxdet_req_q     <= 1'b0;
            eidle_q         <= 1'b1;
            finish_q        <= 1'b0;
            goto_q          <= DETECT_QUIET;
        end else begin
            prev_substate_q <= prev_substate_d;
            os_cnt_q        <= os_cnt_d;
            os_valid_q      <= os_valid_d;
            os_type_q       <= os_type_d;
            link_q          <= link_d;
            rxdet_req_q     <= rxdet_req_d;
            eidle_q         <= eidle_d;
            finish_q        <= finish_d;
            goto_q          <= goto_d;
        end
    end

    assign osValid        = os_valid_q;
    assign osType         = os_type_q;
    assign osLinkNumber   = link_q;
    assign rxDetectReq    = rxdet_req_q;
    assign electricalIdle = eidle_q;
    assign finishTx       = finish_q;
    assign gotoTx         = goto_q;

endmodule
